// File: rtl/mat_row_streamer_if.sv
// Vector stream bus between the matrix streamer and the complex MAC array.
// The master presents one N-lane complex vector per valid/ready handshake.
interface mat_row_streamer_if #(
  parameter int Width = 8,
  parameter int N     = 4
);
  localparam int IW = $clog2(N);

  logic [N*Width-1:0] OutReal;
  logic [N*Width-1:0] OutImag;
  logic [IW-1:0]      OutIdx;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               OUT_LAST;

  modport master (
    output OutReal, OutImag, OutIdx, OUT_VALID, OUT_LAST,
    input  OUT_READY
  );

  modport slave (
    input  OutReal, OutImag, OutIdx, OUT_VALID, OUT_LAST,
    output OUT_READY
  );
endinterface

// File: rtl/mat_row_streamer.sv
// Snapshots an NxN complex matrix on START and streams it row- or column-wise,
// one vector per valid/ready transfer.
module mat_row_streamer #(
  parameter int Width = 8,
  parameter int N     = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic                   MODE,
  input  logic [N*N*Width-1:0]   MatReal,
  input  logic [N*N*Width-1:0]   MatImag,
  mat_row_streamer_if.master     out,
  output logic                   BUSY,
  output logic                   DONE
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]           state;
  logic                 mode_q;
  logic [IW-1:0]        idx;
  logic [N*N*Width-1:0] snap_re;
  logic [N*N*Width-1:0] snap_im;
  logic                 done_q;
  logic [N*Width-1:0]   lane_re;
  logic [N*Width-1:0]   lane_im;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      idx     <= '0;
      snap_re <= '0;
      snap_im <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            snap_re <= MatReal;
            snap_im <= MatImag;
            mode_q  <= MODE;
            idx     <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (out.OUT_READY) begin
            // idx is left at N-1 on completion so the last vector stays on the bus
            if (idx == LAST_IDX) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane k is element (idx,k) in row mode, element (k,idx) in column mode.
  always_comb begin
    lane_re = '0;
    lane_im = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (IW'(j) == idx) begin
          if (mode_q) begin
            lane_re[k*Width +: Width] = snap_re[(k*N + j)*Width +: Width];
            lane_im[k*Width +: Width] = snap_im[(k*N + j)*Width +: Width];
          end else begin
            lane_re[k*Width +: Width] = snap_re[(j*N + k)*Width +: Width];
            lane_im[k*Width +: Width] = snap_im[(j*N + k)*Width +: Width];
          end
        end
      end
    end
  end

  assign out.OutReal   = lane_re;
  assign out.OutImag   = lane_im;
  assign out.OutIdx    = idx;
  assign out.OUT_VALID = (state == STREAM);
  assign out.OUT_LAST  = (state == STREAM) && (idx == LAST_IDX);
  assign BUSY          = (state == STREAM);
  assign DONE          = done_q;
endmodule

// File: tb/tb_mat_row_streamer.sv
// Directed bench for mat_row_streamer: expected vectors are queued when START
// is accepted and compared as the DUT presents them.
module tb_mat_row_streamer;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [N*W-1:0] re;
    logic [N*W-1:0] im;
    logic [IW-1:0]  idx;
    logic           last;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [N*N*W-1:0] mat_re;
  logic [N*N*W-1:0] mat_im;
  logic             busy;
  logic             done;

  mat_row_streamer_if #(.Width(W), .N(N)) bus ();

  mat_row_streamer #(.Width(W), .N(N)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .START   (start),
    .MODE    (mode),
    .MatReal (mat_re),
    .MatImag (mat_im),
    .out     (bus),
    .BUSY    (busy),
    .DONE    (done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  vec_t       q[$];
  vec_t       last_v;
  logic [W-1:0] m_re[N][N];
  logic [W-1:0] m_im[N][N];
  logic       m_mode = 1'b0;
  logic       done_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_matrix(input int base);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        m_re[r][c] = W'(base + 16*r + c);
        m_im[r][c] = W'(-(base + 16*r + c));
        mat_re[(r*N + c)*W +: W] = m_re[r][c];
        mat_im[(r*N + c)*W +: W] = m_im[r][c];
      end
    end
  endtask

  task automatic push_stream();
    vec_t v;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        v.re[k*W +: W] = m_mode ? m_re[k][i] : m_re[i][k];
        v.im[k*W +: W] = m_mode ? m_im[k][i] : m_im[i][k];
      end
      v.idx  = IW'(i);
      v.last = (i == N - 1);
      q.push_back(v);
    end
  endtask

  // One cycle: check what is presented at this negedge, then drive inputs.
  task automatic cyc(input logic rdy, input logic st);
    vec_t v;
    logic streaming;
    @(negedge clk);
    streaming = (q.size() != 0);
    chk("valid", bus.OUT_VALID, streaming);
    chk("busy", busy, streaming);
    chk("done", done, done_exp);
    done_exp = 1'b0;
    if (streaming) begin
      v = q[0];
      chk("idx", bus.OutIdx, v.idx);
      chk("real", bus.OutReal, v.re);
      chk("imag", bus.OutImag, v.im);
      chk("last", bus.OUT_LAST, v.last);
      if (rdy) begin
        last_v = q.pop_front();
        done_exp = (q.size() == 0);
      end
    end else begin
      chk("last_idle", bus.OUT_LAST, 1'b0);
    end
    if (st && !streaming) push_stream();
    ready_drive(rdy, st);
  endtask

  task automatic ready_drive(input logic rdy, input logic st);
    bus.OUT_READY = rdy;
    start = st;
    mode  = m_mode;
  endtask

  task automatic drain();
    for (int i = 0; i < 4*N && q.size() != 0; i++) cyc(1'b1, 1'b0);
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic finish_stream();
    drain();
    cyc(1'b1, 1'b0);
    chk("hold_real", bus.OutReal, last_v.re);
    chk("hold_imag", bus.OutImag, last_v.im);
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    bus.OUT_READY = 1'b0;
    set_matrix(0);

    // Reset and idle
    #12;
    chk("rst_valid", bus.OUT_VALID, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_last", bus.OUT_LAST, 1'b0);
    chk("rst_idx", bus.OutIdx, 0);
    chk("rst_real", bus.OutReal, 0);
    chk("rst_imag", bus.OutImag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc(1'b0, 1'b0);
    chk("idle_real", bus.OutReal, 0);
    chk("idle_imag", bus.OutImag, 0);
    chk("idle_idx", bus.OutIdx, 0);

    // Row mode
    m_mode = 1'b0;
    set_matrix(0);
    cyc(1'b1, 1'b1);
    finish_stream();

    // Column mode; matrix inputs scrambled after capture
    m_mode = 1'b1;
    set_matrix(0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    mat_re = '1;
    mat_im = '1;
    for (int e = 0; e < N*N; e++) begin
      mat_re[e*W +: W] = 8'h7F;
      mat_im[e*W +: W] = 8'h7F;
    end
    finish_stream();

    // Backpressure at idx1 with START re-asserted during the stall
    m_mode = 1'b0;
    set_matrix(2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    finish_stream();

    // Back-to-back: START in the DONE cycle
    m_mode = 1'b0;
    set_matrix(0);
    cyc(1'b1, 1'b1);
    drain();
    m_mode = 1'b1;
    set_matrix(64);
    cyc(1'b1, 1'b1);
    finish_stream();

    // Abort by reset at idx2
    m_mode = 1'b0;
    set_matrix(5);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.OUT_VALID, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_real", bus.OutReal, 0);
    chk("abort_imag", bus.OutImag, 0);
    chk("abort_idx", bus.OutIdx, 0);
    chk("abort_last", bus.OUT_LAST, 1'b0);
    q.delete();
    done_exp = 1'b0;
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (5) cyc(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
